// File: rtl/led_sched_pkg.sv
// Shared types and widths for the LED pattern scheduler.
package led_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int CNT_W  = 4;   // blink count width
    localparam int HALF_W = 10;  // half-period / gap counter width, in ticks

    // Width of a requester index; never less than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Millisecond prescaler: free-running down-counter, tick pulses while it reads 0.
module led_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk50m,
    input  logic reset_n,
    output logic tick_o
);

    localparam int W = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload at zero, otherwise count down.
    always_comb begin
        cnt_d = (cnt_q == '0) ? W'(TICK_DIV - 1) : cnt_q - 1'b1;
    end

    // Prescaler register; cleared by reset so the first tick comes right away.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/led_pattern_sched.sv
// Shares one LED among N_REQ requesters: round-robin pick, play blink pattern,
// led-off gap, then a done pulse to the winner.
// Build option: LED_PRIO_EN gives requester 0 fixed top priority over the ring.
module led_pattern_sched
    import led_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TICK_DIV = 50000,
    parameter int GAP_MS   = 200
) (
    input  logic                    clk50m,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*CNT_W-1:0]  req_count_i,
    input  logic [N_REQ*HALF_W-1:0] req_half_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        done_o,
    output logic                    busy_o,
    output logic                    led_o
);

    localparam int IW = idx_w(N_REQ);
    localparam logic [HALF_W-1:0] GAP_V = HALF_W'(GAP_MS);

    state_e state_q, state_d;

    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]  blinks_q, blinks_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W-1:0] phase_q, phase_d;

    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              busy_q, busy_d;
    logic              led_q, led_d;

    logic              tick;
    logic              phase_end;
    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     ptr_nxt;
    logic [IW:0]       rr_j;
    logic [CNT_W-1:0]  win_cnt;
    logic [HALF_W-1:0] win_half;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk50m  (clk50m),
        .reset_n (reset_n),
        .tick_o  (tick)
    );

    assign phase_end = tick && (phase_q == HALF_W'(1));

    // Arbiter: scan the ring starting at the pointer; the nearest requester wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        rr_j    = '0;
        // Walk farthest-first so the nearest candidate is the last one assigned.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            rr_j = {1'b0, ptr_q} + (IW+1)'(k);
            if (rr_j >= (IW+1)'(N_REQ)) rr_j = rr_j - (IW+1)'(N_REQ);
            if (req_i[rr_j[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = rr_j[IW-1:0];
            end
        end
`ifdef LED_PRIO_EN
        // Requester 0 overrides the ring; the rest still rotate among themselves.
        if (req_i[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
        end
`endif
        ptr_nxt  = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        win_cnt  = req_count_i[int'(win_idx)*CNT_W +: CNT_W];
        win_half = req_half_i[int'(win_idx)*HALF_W +: HALF_W];
        // A zero half-period would never end a phase; run it as one tick.
        if (win_half == '0) win_half = HALF_W'(1);
    end

    // State register.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_vld) state_d = (win_cnt == '0) ? ST_DONE : ST_ON;
            ST_ON:   if (phase_end) state_d = ST_OFF;
            ST_OFF:  if (phase_end) state_d = (blinks_q > CNT_W'(1)) ? ST_ON : ST_GAP;
            ST_GAP:  if (phase_end) state_d = ST_DONE;
            // A zero-count grant lands here without having pulsed done yet, so it
            // stays one extra cycle to report; otherwise leave after the pulse.
            ST_DONE: if (done_q != '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch the winning pattern, run the phase and blink counters.
    always_comb begin
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        blinks_d = blinks_q;
        half_d   = half_q;
        phase_d  = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    idx_d    = win_idx;
                    blinks_d = win_cnt;
                    half_d   = win_half;
                    phase_d  = win_half;
`ifdef LED_PRIO_EN
                    if (win_idx != '0) ptr_d = ptr_nxt;
`else
                    ptr_d = ptr_nxt;
`endif
                end
            end
            ST_ON: begin
                if (phase_end) phase_d = half_q;
                else if (tick) phase_d = phase_q - 1'b1;
            end
            ST_OFF: begin
                if (phase_end) begin
                    blinks_d = blinks_q - 1'b1;
                    phase_d  = (blinks_q > CNT_W'(1)) ? half_q : GAP_V;
                end else if (tick) begin
                    phase_d = phase_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (tick && !phase_end) phase_d = phase_q - 1'b1;
            end
            default: ;
        endcase
    end

    // Output decode from the upcoming state so every output is registered in step.
    always_comb begin
        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
        gnt_d  = '0;
        done_d = '0;
        if (state_q == ST_IDLE && win_vld) gnt_d = N_REQ'(1) << win_idx;
        if (state_d == ST_DONE && state_q != ST_IDLE) done_d = N_REQ'(1) << idx_q;
    end

    // Datapath and output registers.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q    <= '0;
            idx_q    <= '0;
            blinks_q <= '0;
            half_q   <= '0;
            phase_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            blinks_q <= blinks_d;
            half_q   <= half_d;
            phase_q  <= phase_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign busy_o = busy_q;
    assign led_o  = led_q;

endmodule
